// File: rtl/mc_pkg.sv
// Shared encodings for the MIPS-lite multi-cycle controller, extender and ALU.
package mc_pkg;

  // Opcodes (IR[31:26]) and R-type function codes (IR[5:0])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSubu  = 6'b100011;

  // Extender select
  localparam logic [1:0] ExtZero = 2'b00;
  localparam logic [1:0] ExtSign = 2'b01;
  localparam logic [1:0] ExtHigh = 2'b10;

  // ALU operation
  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluOr  = 2'b10;

  // Next-PC select
  localparam logic [1:0] NpcPc4    = 2'b00;
  localparam logic [1:0] NpcBranch = 2'b01;
  localparam logic [1:0] NpcJump   = 2'b10;

  // Register-file destination select
  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExe    = 4'd2,
    StAluWb  = 4'd3,
    StMadr   = 4'd4,
    StMrd    = 4'd5,
    StMwb    = 4'd6,
    StMwr    = 4'd7,
    StBr     = 4'd8,
    StJmp    = 4'd9
  } state_e;

  // One-hot instruction class; all-zero means unsupported
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
  } cls_t;

  function automatic logic is_rtype(cls_t c);
    return c.addu | c.subu;
  endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: IR fields and flags in, strobes and selects out.
interface mc_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             PCWr;
  logic             IRWr;
  logic             RegWr;
  logic             MemWr;
  logic [1:0]       ExtOp;
  logic [1:0]       ALUOp;
  logic             ALUSrc;
  logic [1:0]       RegDst;
  logic             MemtoReg;
  logic [1:0]       NPCOp;
  logic [CNT_W-1:0] instr_cnt;
  logic             illegal;

  // Controller side
  modport master (
    input  op, funct, zero,
    output PCWr, IRWr, RegWr, MemWr, ExtOp, ALUOp, ALUSrc, RegDst, MemtoReg, NPCOp,
    output instr_cnt, illegal
  );

  // Datapath side
  modport slave (
    output op, funct, zero,
    input  PCWr, IRWr, RegWr, MemWr, ExtOp, ALUOp, ALUSrc, RegDst, MemtoReg, NPCOp,
    input  instr_cnt, illegal
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational op/funct decoder: one-hot instruction class plus unsupported flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       illegal
);

  // Map opcode (and funct for R-type) onto a class bit
  always_comb begin
    cls = '0;
    case (op)
      OpRtype: begin
        cls.addu = (funct == FnAddu);
        cls.subu = (funct == FnSubu);
      end
      OpOri:   cls.ori = 1'b1;
      OpLui:   cls.lui = 1'b1;
      OpLw:    cls.lw  = 1'b1;
      OpSw:    cls.sw  = 1'b1;
      OpBeq:   cls.beq = 1'b1;
      OpJ:     cls.j   = 1'b1;
      default: cls = '0;
    endcase
    illegal = (cls == '0);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences each instruction and drives datapath controls.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  mc_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;

  cls_t cls;
  logic dec_illegal;

  logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_src, mem_to_reg, retire;
  logic [1:0] ext_op, alu_op, reg_dst, npc_op;
  logic [1:0] exe_ext_op, exe_alu_op;
  logic       exe_alu_src;

  mc_decode u_decode (
    .op      (bus.op),
    .funct   (bus.funct),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  // ALU-class selects, shared by StExe and StAluWb
  always_comb begin
    exe_alu_op  = AluAdd;
    exe_alu_src = 1'b0;
    exe_ext_op  = ExtZero;
    if (cls.subu) begin
      exe_alu_op = AluSub;
    end else if (cls.ori || cls.lui) begin
      exe_alu_op  = AluOr;
      exe_alu_src = 1'b1;
      exe_ext_op  = cls.lui ? ExtHigh : ExtZero;
    end
  end

  // Next state, counter/flag updates and Moore outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ill_d      = ill_q;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    ext_op     = ExtZero;
    alu_op     = AluAdd;
    alu_src    = 1'b0;
    reg_dst    = RegDstRt;
    mem_to_reg = 1'b0;
    npc_op     = NpcPc4;
    retire     = 1'b0;
    case (state_q)
      StFetch: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        if (dec_illegal) begin
          ill_d   = 1'b1;
          state_d = StFetch;
        end else if (is_rtype(cls) || cls.ori || cls.lui) begin
          state_d = StExe;
        end else if (cls.lw || cls.sw) begin
          state_d = StMadr;
        end else if (cls.beq) begin
          state_d = StBr;
        end else begin
          state_d = StJmp;
        end
      end
      StExe: begin
        alu_op  = exe_alu_op;
        alu_src = exe_alu_src;
        ext_op  = exe_ext_op;
        state_d = StAluWb;
      end
      StAluWb: begin
        alu_op  = exe_alu_op;
        alu_src = exe_alu_src;
        ext_op  = exe_ext_op;
        reg_wr  = 1'b1;
        reg_dst = is_rtype(cls) ? RegDstRd : RegDstRt;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StMadr, StMrd, StMwr: begin
        // Address computation selects stay up through the memory access
        alu_op  = AluAdd;
        alu_src = 1'b1;
        ext_op  = ExtSign;
        if (state_q == StMadr) begin
          state_d = cls.lw ? StMrd : StMwr;
        end else if (state_q == StMrd) begin
          state_d = StMwb;
        end else begin
          mem_wr  = 1'b1;
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StMwb: begin
        reg_wr     = 1'b1;
        reg_dst    = RegDstRt;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StBr: begin
        alu_op  = AluSub;
        ext_op  = ExtSign;
        npc_op  = NpcBranch;
        pc_wr   = bus.zero;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StJmp: begin
        pc_wr   = 1'b1;
        npc_op  = NpcJump;
        retire  = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, retired count and sticky illegal flag; synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  // Everything reads as zero while reset is held, so no strobe fires in a reset cycle
  always_comb begin
    bus.PCWr      = rst_n & pc_wr;
    bus.IRWr      = rst_n & ir_wr;
    bus.RegWr     = rst_n & reg_wr;
    bus.MemWr     = rst_n & mem_wr;
    bus.ExtOp     = rst_n ? ext_op : 2'b00;
    bus.ALUOp     = rst_n ? alu_op : 2'b00;
    bus.ALUSrc    = rst_n & alu_src;
    bus.RegDst    = rst_n ? reg_dst : 2'b00;
    bus.MemtoReg  = rst_n & mem_to_reg;
    bus.NPCOp     = rst_n ? npc_op : 2'b00;
    bus.instr_cnt = rst_n ? cnt_q : '0;
    bus.illegal   = rst_n & ill_q;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS-lite datapath; sits directly upstream of the immediate extender and drives its ExtOp select.
- Decodes op/funct from the instruction register and sequences each instruction through Fetch/Decode/Execute/Memory/Writeback states.
- Emits the write strobes and the datapath mux selects, a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
op  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, valid in S_BR
PCWr  out  1  PC write enable
IRWr  out  1  instruction register write enable
RegWr  out  1  register file write enable
MemWr  out  1  data memory write enable
ExtOp  out  2  to extender: 00 zero-ext, 01 sign-ext, 10 imm<<16
ALUOp  out  2  00 add, 01 sub, 10 or
ALUSrc  out  1  0 reg B, 1 extended immediate
RegDst  out  2  00 rt, 01 rd
MemtoReg  out  1  0 ALU result, 1 memory data
NPCOp  out  2  00 PC+4, 01 branch target, 10 jump target
instr_cnt  out  CNT_W  retired-instruction count
illegal  out  1  sticky: unsupported opcode/funct decoded

Behaviour:
- Reset: sampled on the rising clk edge only. While rst_n=0, state<=S_FETCH, instr_cnt<=0 and illegal<=0 at each edge. During rst_n=0 the outputs PCWr, IRWr, RegWr and MemWr are forced to 0 combinationally. All other outputs are 0 during reset.
- A reset asserted mid-instruction abandons that instruction. No strobe fires in the reset cycle. Execution restarts in S_FETCH.
- Outputs are Moore-style, decoded from the current state and the held op/funct. IR is stable from S_DECODE onward. Outputs not listed for a state are 0.
- Supported instructions:
  - addu: op 000000, funct 100001
  - subu: op 000000, funct 100011
  - ori: op 001101
  - lw: op 100011
  - sw: op 101011
  - beq: op 000100
  - lui: op 001111
  - j: op 000010
- State behaviour:
  - S_FETCH: IRWr=1, PCWr=1, NPCOp=00. Next state S_DECODE.
  - S_DECODE: no strobes. Next state by class:
    - R-type, ori, lui -> S_EXE
    - lw, sw -> S_MADR
    - beq -> S_BR
    - j -> S_JMP
    - anything else -> illegal<=1, S_FETCH. The instruction is not counted.
  - S_EXE:
    - addu: ALUOp=00, ALUSrc=0
    - subu: ALUOp=01, ALUSrc=0
    - ori: ALUOp=10, ALUSrc=1, ExtOp=00
    - lui: ALUOp=10, ALUSrc=1, ExtOp=10
    - Selects are held into S_ALUWB. Next state S_ALUWB.
  - S_ALUWB: RegWr=1, MemtoReg=0. RegDst=01 for R-type, 00 otherwise. Retires. Next state S_FETCH.
  - S_MADR: ALUOp=00, ALUSrc=1, ExtOp=01. Next state S_MRD for lw, S_MWR for sw.
  - S_MRD: address selects held. Next state S_MWB.
  - S_MWB: RegWr=1, RegDst=00, MemtoReg=1. Retires. Next state S_FETCH.
  - S_MWR: MemWr=1, address selects held. Retires. Next state S_FETCH.
  - S_BR: ALUOp=01, ALUSrc=0, ExtOp=01, NPCOp=01, PCWr=zero. Retires regardless of zero. Next state S_FETCH.
  - S_JMP: PCWr=1, NPCOp=10. Retires. Next state S_FETCH.
- Cycles per instruction: R-type, ori, lui = 4; lw = 5; sw = 4; beq = 3; j = 3.
- instr_cnt increments by 1 on the edge leaving a retiring state. It wraps from 2^CNT_W-1 to 0 with no flag.
- illegal stays set until reset. The controller keeps running after an illegal decode.
- Unreachable state encodings go to S_FETCH on the next edge with all strobes 0.

Decomposition:
- Shared package mc_pkg holds:
  - opcode and funct constants
  - state encoding (4-bit enum)
  - ExtOp, ALUOp and NPCOp encodings, reused by the extender and ALU
- One sub-module, mc_decode: combinational op/funct to instruction-class one-hot plus an illegal bit. The FSM and counter stay in mc_ctrl.

Test Plan:
- Reset: rst_n=0 for 3 cycles with op=100011 -> all outputs 0 and no strobe. First cycle after release is S_FETCH with IRWr=1, PCWr=1.
- lw (op=100011) -> 5 cycles. ExtOp=01, ALUSrc=1 in cycle 3. RegWr=1, MemtoReg=1 in cycle 5. instr_cnt 0->1.
- ori (op=001101) then lui (op=001111) -> ExtOp=00 then 10, ALUOp=10, RegDst=00, 4 cycles each. instr_cnt=2.
- beq with zero=1, then with zero=0 -> PCWr=1 and NPCOp=01 in cycle 3 for the first, PCWr=0 for the second. Both counted.
- op=111111 -> illegal=1 after S_DECODE, returns to S_FETCH, instr_cnt unchanged, illegal stays 1 until rst_n=0.
- rst_n=0 during S_MWR of sw -> MemWr=0 that cycle, state S_FETCH after release, instr_cnt=0.
